// File: rtl/pipeline_stall_control_if.sv
// Hazard inputs and pipeline-register controls exchanged between
// the datapath (master) and the stall controller (slave).
interface pipeline_stall_control_if;
  logic IDstall;
  logic EXstall;
  logic IDbranch_taken;
  logic IDjump;
  logic PCwrite;
  logic IFIDwrite;
  logic IDEXwrite;
  logic EXMEMwrite;
  logic IFIDflush;
  logic IDEXbubble;
  logic EXMEMbubble;

  modport master (
    output IDstall, EXstall,
    output IDbranch_taken, IDjump,
    input  PCwrite, IFIDwrite,
    input  IDEXwrite, EXMEMwrite,
    input  IFIDflush, IDEXbubble,
    input  EXMEMbubble
  );

  modport slave (
    input  IDstall, EXstall,
    input  IDbranch_taken, IDjump,
    output PCwrite, IFIDwrite,
    output IDEXwrite, EXMEMwrite,
    output IFIDflush, IDEXbubble,
    output EXMEMbubble
  );
endinterface

// File: rtl/pipeline_stall_control.sv
// Stall/flush control for the 5-stage pipeline: write enables,
// bubbles, per-stage valid bits, event counters, deadlock flag.
module pipeline_stall_control #(
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_stall_control_if.slave hz,
  output logic             valid_IFID,
  output logic             valid_IDEX,
  output logic             valid_EXMEM,
  output logic             valid_MEMWB,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] retired_count,
  output logic             deadlock
);

  localparam logic [3:0] LIM = 4'(STALL_LIMIT);

  logic       stall;
  logic       flush;
  logic [3:0] run;
  logic [3:0] run_nxt;

  assign stall = hz.IDstall | hz.EXstall;
  assign flush = (hz.IDbranch_taken | hz.IDjump) & ~stall;
  assign run_nxt = !stall ? 4'd0 :
                   (run == 4'hf) ? 4'hf : run + 4'd1;

  always_comb begin
    hz.PCwrite     = 1'b0;
    hz.IFIDwrite   = 1'b0;
    hz.IDEXwrite   = 1'b0;
    hz.EXMEMwrite  = 1'b0;
    hz.IFIDflush   = 1'b0;
    hz.IDEXbubble  = 1'b0;
    hz.EXMEMbubble = 1'b0;
    priority case (1'b1)
      reset: ;
      // EX/MEM is still written, but with the NOP
      hz.EXstall: begin
        hz.EXMEMwrite  = 1'b1;
        hz.EXMEMbubble = 1'b1;
      end
      hz.IDstall: begin
        hz.IDEXwrite  = 1'b1;
        hz.EXMEMwrite = 1'b1;
        hz.IDEXbubble = 1'b1;
      end
      default: begin
        hz.PCwrite    = 1'b1;
        hz.IFIDwrite  = 1'b1;
        hz.IDEXwrite  = 1'b1;
        hz.EXMEMwrite = 1'b1;
        hz.IFIDflush  = flush;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_IFID  <= 1'b0;
      valid_IDEX  <= 1'b0;
      valid_EXMEM <= 1'b0;
      valid_MEMWB <= 1'b0;
    end else begin
      valid_MEMWB <= valid_EXMEM;
      valid_EXMEM <= hz.EXstall ? 1'b0 : valid_IDEX;
      if (!hz.EXstall)
        valid_IDEX <= hz.IDstall ? 1'b0 : valid_IFID;
      if (!stall)
        valid_IFID <= !flush;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count   <= '0;
      flush_count   <= '0;
      retired_count <= '0;
    end else begin
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (flush && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
      if (valid_MEMWB && retired_count != '1)
        retired_count <= retired_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run      <= 4'd0;
      deadlock <= 1'b0;
    end else begin
      run <= run_nxt;
      if (stall && run_nxt == LIM)
        deadlock <= 1'b1;
    end
  end

endmodule
